// File: rtl/cpu_info_writer.sv
// Purpose: on start, writes a 38-character text line "PC:hhhh A:hh X:hh Y:hh S:hh P:hh OP:hh" into VRAM, colouring changed fields.
// Latency: first character is on the bus the cycle after start; done pulses 39 cycles after start plus any stall cycles.
// Backpressure: v_stall freezes the presented character, address and colour until the write is taken; stalls may last any length.
module cpu_info_writer #(
  parameter logic [9:0] BASE_ADDR   = 10'd960,
  parameter logic [3:0] COLOR_LABEL = 4'h7,
  parameter logic [3:0] COLOR_VALUE = 4'hF,
  parameter logic [3:0] COLOR_DIFF  = 4'h9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] pc,
  input  logic [7:0]  a,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  input  logic [7:0]  sp,
  input  logic [7:0]  p,
  input  logic [7:0]  opcode,
  input  logic        v_stall,
  output logic        busy,
  output logic        done,
  output logic [9:0]  v_ada,
  output logic [7:0]  v_din,
  output logic [3:0]  v_din_t,
  output logic        vram_write
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [5:0] LAST_IDX = 6'd37;

  state_t      state;
  logic [5:0]  index;

  // Snapshot captured when the dump starts; the dump only ever reads these.
  logic [15:0] snap_pc;
  logic [7:0]  snap_a, snap_x, snap_y, snap_sp, snap_p, snap_op;

  // Snapshot of the previous completed dump, used to highlight changed fields.
  logic [15:0] prev_pc;
  logic [7:0]  prev_a, prev_x, prev_y, prev_sp, prev_p, prev_op;

  // Character about to be loaded into the output registers.
  logic [5:0]  sel_idx;
  logic [15:0] sel_pc;
  logic [7:0]  sel_a, sel_x, sel_y, sel_sp, sel_p, sel_op;
  logic        d_pc, d_a, d_x, d_y, d_sp, d_p, d_op;
  logic        is_digit;
  logic        fdiff;
  logic [3:0]  nib;
  logic [7:0]  ch_din;
  logic [3:0]  ch_t;
  logic [9:0]  ch_ada;
  logic        accept;

  assign accept = vram_write & ~v_stall;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

  // Pick which character comes next: index 0 of the live inputs when starting, else the following index of the latched snapshot.
  always_comb begin
    if (state == IDLE) begin
      sel_idx = 6'd0;
      sel_pc  = pc;
      sel_a   = a;
      sel_x   = x;
      sel_y   = y;
      sel_sp  = sp;
      sel_p   = p;
      sel_op  = opcode;
    end else begin
      sel_idx = index + 6'd1;
      sel_pc  = snap_pc;
      sel_a   = snap_a;
      sel_x   = snap_x;
      sel_y   = snap_y;
      sel_sp  = snap_sp;
      sel_p   = snap_p;
      sel_op  = snap_op;
    end
    d_pc = (sel_pc != prev_pc);
    d_a  = (sel_a  != prev_a);
    d_x  = (sel_x  != prev_x);
    d_y  = (sel_y  != prev_y);
    d_sp = (sel_sp != prev_sp);
    d_p  = (sel_p  != prev_p);
    d_op = (sel_op != prev_op);
  end

  // Map a character index to its glyph and colour; anything not listed is a space.
  always_comb begin
    ch_din   = 8'h20;
    is_digit = 1'b0;
    nib      = 4'h0;
    fdiff    = 1'b0;
    case (sel_idx)
      6'd0:  ch_din = "P";
      6'd1:  ch_din = "C";
      6'd2:  ch_din = ":";
      6'd3:  begin is_digit = 1'b1; nib = sel_pc[15:12]; fdiff = d_pc; end
      6'd4:  begin is_digit = 1'b1; nib = sel_pc[11:8];  fdiff = d_pc; end
      6'd5:  begin is_digit = 1'b1; nib = sel_pc[7:4];   fdiff = d_pc; end
      6'd6:  begin is_digit = 1'b1; nib = sel_pc[3:0];   fdiff = d_pc; end
      6'd8:  ch_din = "A";
      6'd9:  ch_din = ":";
      6'd10: begin is_digit = 1'b1; nib = sel_a[7:4];  fdiff = d_a; end
      6'd11: begin is_digit = 1'b1; nib = sel_a[3:0];  fdiff = d_a; end
      6'd13: ch_din = "X";
      6'd14: ch_din = ":";
      6'd15: begin is_digit = 1'b1; nib = sel_x[7:4];  fdiff = d_x; end
      6'd16: begin is_digit = 1'b1; nib = sel_x[3:0];  fdiff = d_x; end
      6'd18: ch_din = "Y";
      6'd19: ch_din = ":";
      6'd20: begin is_digit = 1'b1; nib = sel_y[7:4];  fdiff = d_y; end
      6'd21: begin is_digit = 1'b1; nib = sel_y[3:0];  fdiff = d_y; end
      6'd23: ch_din = "S";
      6'd24: ch_din = ":";
      6'd25: begin is_digit = 1'b1; nib = sel_sp[7:4]; fdiff = d_sp; end
      6'd26: begin is_digit = 1'b1; nib = sel_sp[3:0]; fdiff = d_sp; end
      6'd28: ch_din = "P";
      6'd29: ch_din = ":";
      6'd30: begin is_digit = 1'b1; nib = sel_p[7:4];  fdiff = d_p; end
      6'd31: begin is_digit = 1'b1; nib = sel_p[3:0];  fdiff = d_p; end
      6'd33: ch_din = "O";
      6'd34: ch_din = "P";
      6'd35: ch_din = ":";
      6'd36: begin is_digit = 1'b1; nib = sel_op[7:4]; fdiff = d_op; end
      6'd37: begin is_digit = 1'b1; nib = sel_op[3:0]; fdiff = d_op; end
      default: ch_din = 8'h20;
    endcase
    if (is_digit) ch_din = hex_char(nib);
    if (is_digit) ch_t = fdiff ? COLOR_DIFF : COLOR_VALUE;
    else          ch_t = COLOR_LABEL;
    // 10-bit sum wraps naturally past the top of VRAM.
    ch_ada = BASE_ADDR + {4'd0, sel_idx};
  end

  // Control FSM with registered VRAM command, status and snapshot registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      index      <= 6'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      vram_write <= 1'b0;
      v_ada      <= 10'd0;
      v_din      <= 8'd0;
      v_din_t    <= 4'd0;
      snap_pc    <= 16'd0;
      snap_a     <= 8'd0;
      snap_x     <= 8'd0;
      snap_y     <= 8'd0;
      snap_sp    <= 8'd0;
      snap_p     <= 8'd0;
      snap_op    <= 8'd0;
      prev_pc    <= 16'd0;
      prev_a     <= 8'd0;
      prev_x     <= 8'd0;
      prev_y     <= 8'd0;
      prev_sp    <= 8'd0;
      prev_p     <= 8'd0;
      prev_op    <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            snap_pc    <= pc;
            snap_a     <= a;
            snap_x     <= x;
            snap_y     <= y;
            snap_sp    <= sp;
            snap_p     <= p;
            snap_op    <= opcode;
            index      <= 6'd0;
            state      <= WRITE;
            busy       <= 1'b1;
            vram_write <= 1'b1;
            v_ada      <= ch_ada;
            v_din      <= ch_din;
            v_din_t    <= ch_t;
          end
        end
        WRITE: begin
          if (accept) begin
            if (index == LAST_IDX) begin
              state      <= DONE;
              done       <= 1'b1;
              vram_write <= 1'b0;
              v_ada      <= 10'd0;
              v_din      <= 8'd0;
              v_din_t    <= 4'd0;
            end else begin
              index   <= index + 6'd1;
              v_ada   <= ch_ada;
              v_din   <= ch_din;
              v_din_t <= ch_t;
            end
          end
        end
        DONE: begin
          prev_pc <= snap_pc;
          prev_a  <= snap_a;
          prev_x  <= snap_x;
          prev_y  <= snap_y;
          prev_sp <= snap_sp;
          prev_p  <= snap_p;
          prev_op <= snap_op;
          index   <= 6'd0;
          done    <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          done       <= 1'b0;
          vram_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_info_writer.sv
// Bench for cpu_info_writer: two instances (default base and a base near the top of VRAM) share stimulus.
// Expected characters are queued per instance when a dump is started and popped on every accepted write.
// Table of dump vectors plus hand sequences for start-during-dump and reset-during-dump.
module tb_cpu_info_writer;

  localparam logic [3:0] C_LABEL = 4'h7;
  localparam logic [3:0] C_VALUE = 4'hF;
  localparam logic [3:0] C_DIFF  = 4'h9;

  logic        clk = 1'b0;
  logic        rst, start, v_stall;
  logic [15:0] pc;
  logic [7:0]  a, x, y, sp, p, opcode;
  logic        busy1, done1, vram_write1, busy2, done2, vram_write2;
  logic [9:0]  v_ada1, v_ada2;
  logic [7:0]  v_din1, v_din2;
  logic [3:0]  v_din_t1, v_din_t2;

  always #5 clk = ~clk;

  cpu_info_writer dut1 (
    .clk(clk), .rst(rst), .start(start), .pc(pc), .a(a), .x(x), .y(y), .sp(sp), .p(p),
    .opcode(opcode), .v_stall(v_stall), .busy(busy1), .done(done1), .v_ada(v_ada1),
    .v_din(v_din1), .v_din_t(v_din_t1), .vram_write(vram_write1)
  );

  cpu_info_writer #(.BASE_ADDR(10'h3F0)) dut2 (
    .clk(clk), .rst(rst), .start(start), .pc(pc), .a(a), .x(x), .y(y), .sp(sp), .p(p),
    .opcode(opcode), .v_stall(v_stall), .busy(busy2), .done(done2), .v_ada(v_ada2),
    .v_din(v_din2), .v_din_t(v_din_t2), .vram_write(vram_write2)
  );

  typedef struct {
    logic [9:0] ada;
    logic [7:0] din;
    logic [3:0] t;
  } exp_t;

  typedef struct {
    logic [15:0] pc;
    logic [7:0]  a, x, y, sp, p, op;
    int          stall_idx;
    int          stall_len;
    logic [6:0]  mask;      // changed fields, {pc,a,x,y,sp,p,op}
    int          exp_done;  // cycles from start acceptance to done
  } vec_t;

  exp_t q1[$];
  exp_t q2[$];
  logic [7:0] exp_din[38];
  logic [9:0] log2_ada[64];
  int cnt2;
  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard for the default-base instance.
  always @(negedge clk) begin : mon1
    exp_t e;
    if (vram_write1 && !v_stall) begin
      if (q1.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL dut1 unexpected write: got ada %0d din %0h expected no write", v_ada1, v_din1);
      end else begin
        e = q1.pop_front();
        chk("dut1 ada", 32'(v_ada1), 32'(e.ada));
        chk("dut1 din", 32'(v_din1), 32'(e.din));
        chk("dut1 color", 32'(v_din_t1), 32'(e.t));
      end
    end
  end

  // Scoreboard for the high-base instance, also logging addresses for wrap checks.
  always @(negedge clk) begin : mon2
    exp_t e;
    if (vram_write2 && !v_stall) begin
      if (cnt2 < 64) log2_ada[cnt2] = v_ada2;
      cnt2++;
      if (q2.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL dut2 unexpected write: got ada %0h expected no write", v_ada2);
      end else begin
        e = q2.pop_front();
        chk("dut2 ada", 32'(v_ada2), 32'(e.ada));
        chk("dut2 din", 32'(v_din2), 32'(e.din));
        chk("dut2 color", 32'(v_din_t2), 32'(e.t));
      end
    end
  end

  // Build the expected text line from a formatted string and a field-position template.
  task automatic push_expected(input vec_t v);
    string s, tmpl;
    logic [7:0] c, f;
    logic [3:0] col;
    int fi;
    tmpl = "LLL0000LLL11LLL22LLL33LLL44LLL55LLLL66";
    s = $sformatf("PC:%h A:%h X:%h Y:%h S:%h P:%h OP:%h", v.pc, v.a, v.x, v.y, v.sp, v.p, v.op);
    for (int i = 0; i < 38; i++) begin
      c = s[i];
      if (c >= "a" && c <= "f") c = c - 8'd32;
      f = tmpl[i];
      if (f == "L") col = C_LABEL;
      else begin
        fi = int'(f) - 48;
        col = v.mask[6 - fi] ? C_DIFF : C_VALUE;
      end
      exp_din[i] = c;
      q1.push_back('{ada: 10'(960 + i), din: c, t: col});
      q2.push_back('{ada: 10'(32'h3F0 + i), din: c, t: col});
    end
  endtask

  // Start one dump; optionally pulse start or assert reset at a given cycle after acceptance.
  task automatic run_dump(input vec_t v, input int pulse_at, input int rst_at, input string tag);
    int cyc;
    push_expected(v);
    cnt2 = 0;
    pc = v.pc; a = v.a; x = v.x; y = v.y; sp = v.sp; p = v.p; opcode = v.op;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Disturb the inputs; the dump must keep showing the latched values.
    pc = ~v.pc; a = ~v.a; x = ~v.x; y = ~v.y; sp = ~v.sp; p = ~v.p; opcode = ~v.op;
    chk({tag, " busy after start"}, 32'(busy1), 32'd1);
    cyc = 0;
    while (cyc < 300) begin
      v_stall = (v.stall_len > 0 && cyc >= v.stall_idx && cyc < v.stall_idx + v.stall_len);
      start   = (cyc == pulse_at);
      rst     = (cyc == rst_at);
      if (v_stall) begin
        chk({tag, " stall hold ada"}, 32'(v_ada1), 32'(960 + v.stall_idx));
        chk({tag, " stall hold din"}, 32'(v_din1), 32'(exp_din[v.stall_idx]));
      end
      @(posedge clk); #1;
      cyc++;
      if (rst_at >= 0 && cyc == rst_at + 1) break;
      if (done1) break;
    end
    v_stall = 1'b0;
    start   = 1'b0;
    rst     = 1'b0;
    if (rst_at >= 0) begin
      chk({tag, " write after reset"}, 32'(vram_write1), 32'd0);
      chk({tag, " busy after reset"}, 32'(busy1), 32'd0);
      chk({tag, " ada after reset"}, 32'(v_ada1), 32'd0);
      for (int k = 0; k < 5; k++) begin
        chk({tag, " no done after abort"}, 32'(done1), 32'd0);
        chk({tag, " no write after abort"}, 32'(vram_write1), 32'd0);
        @(posedge clk); #1;
      end
      q1.delete();
      q2.delete();
    end else begin
      chk({tag, " done latency"}, 32'(cyc), 32'(v.exp_done));
      chk({tag, " dut2 done"}, 32'(done2), 32'd1);
      chk({tag, " busy with done"}, 32'(busy1), 32'd1);
      @(posedge clk); #1;
      chk({tag, " done one cycle"}, 32'(done1), 32'd0);
      chk({tag, " busy cleared"}, 32'(busy1), 32'd0);
      for (int k = 0; k < 3; k++) begin
        @(posedge clk); #1;
        chk({tag, " idle no write"}, 32'(vram_write1), 32'd0);
      end
      chk({tag, " dut1 queue drained"}, 32'(q1.size()), 32'd0);
      chk({tag, " dut2 queue drained"}, 32'(q2.size()), 32'd0);
    end
  endtask

  initial begin
    vec_t tbl[4];
    vec_t sa, sb, sc;
    tbl[0] = '{pc: 16'h1234, a: 8'hAB, x: 8'h00, y: 8'h00, sp: 8'hFD, p: 8'h24, op: 8'hEA,
               stall_idx: 0, stall_len: 0, mask: 7'b1100111, exp_done: 38};
    tbl[1] = '{pc: 16'h1234, a: 8'hAB, x: 8'h00, y: 8'h00, sp: 8'hFD, p: 8'h24, op: 8'hEA,
               stall_idx: 0, stall_len: 0, mask: 7'b0000000, exp_done: 38};
    tbl[2] = '{pc: 16'h1234, a: 8'hAB, x: 8'h01, y: 8'h00, sp: 8'hFD, p: 8'h24, op: 8'hEA,
               stall_idx: 0, stall_len: 0, mask: 7'b0010000, exp_done: 38};
    tbl[3] = '{pc: 16'h1234, a: 8'hAB, x: 8'h01, y: 8'h00, sp: 8'hFD, p: 8'h24, op: 8'hEA,
               stall_idx: 10, stall_len: 5, mask: 7'b0000000, exp_done: 43};
    sa = '{pc: 16'hBEEF, a: 8'h11, x: 8'h22, y: 8'h33, sp: 8'h44, p: 8'h55, op: 8'h66,
           stall_idx: 0, stall_len: 0, mask: 7'b1111111, exp_done: 38};
    sb = sa;
    sb.mask = 7'b0000000;
    sc = sa;

    cnt2 = 0;
    v_stall = 1'b0;
    pc = 16'h0; a = 8'h0; x = 8'h0; y = 8'h0; sp = 8'h0; p = 8'h0; opcode = 8'h0;
    // Reset with start held high: reset must win.
    rst = 1'b1;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b0;
    chk("reset busy", 32'(busy1), 32'd0);
    chk("reset done", 32'(done1), 32'd0);
    chk("reset vram_write", 32'(vram_write1), 32'd0);
    chk("reset v_ada", 32'(v_ada1), 32'd0);
    chk("reset v_din", 32'(v_din1), 32'd0);
    chk("reset v_din_t", 32'(v_din_t1), 32'd0);
    @(posedge clk); #1;
    chk("start ignored under reset", 32'(busy1), 32'd0);

    for (int i = 0; i < 4; i++) run_dump(tbl[i], -1, -1, $sformatf("vec%0d", i));

    chk("wrap index15", 32'(log2_ada[15]), 32'h3FF);
    chk("wrap index16", 32'(log2_ada[16]), 32'h000);
    chk("wrap index37", 32'(log2_ada[37]), 32'h015);
    chk("wrap count", 32'(cnt2), 32'd38);

    run_dump(sa, 20, -1, "start-in-write");
    run_dump(sb, -1, 20, "reset-in-write");
    run_dump(sc, -1, -1, "after-abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
